// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - execution-unit and divider2 signal bundle for div_sequencer
interface div_sequencer_if;
  logic        req;
  logic        wide;
  logic        is_signed;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic        div_error;
  logic [15:0] quot_out;
  logic [15:0] rem_out;
  logic        dv_start;
  logic        dv_signed;
  logic [31:0] dv_num;
  logic [31:0] dv_denom;
  logic        dv_done;
  logic [31:0] dv_quot;
  logic [31:0] dv_rem;

  // master: execution unit plus divider2 side; slave: the sequencer itself
  modport master (
    output req, wide, is_signed, dividend, divisor, dv_done, dv_quot, dv_rem,
    input  busy, done, div_error, quot_out, rem_out, dv_start, dv_signed, dv_num, dv_denom
  );

  modport slave (
    input  req, wide, is_signed, dividend, divisor, dv_done, dv_quot, dv_rem,
    output busy, done, div_error, quot_out, rem_out, dv_start, dv_signed, dv_num, dv_denom
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - DIV/IDIV control stage: operand extension, divider2 issue, x86 range/zero checks
module div_sequencer #(
  parameter bit SIGNED_MIN_VALID = 1'b1
) (
  input logic            clk,
  input logic            reset,
  input logic            ce,
  div_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  logic [2:0]  state;
  logic        lat_wide;
  logic        lat_signed;
  logic        dbz_pending;
  logic [31:0] num_r;
  logic [31:0] denom_r;
  logic [31:0] q_cap;
  logic [15:0] r_cap;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        start_r;
  logic [15:0] quot_r;
  logic [15:0] rem_r;

  logic [31:0] ext_num;
  logic [31:0] ext_denom;
  logic        ovf;
  logic        unused_rem_hi;

  assign unused_rem_hi = ^bus.dv_rem[31:16];

  always_comb begin
    ext_num   = 32'h0;
    ext_denom = 32'h0;
    if (bus.wide) begin
      ext_num   = bus.dividend;
      ext_denom = bus.is_signed ? {{16{bus.divisor[15]}}, bus.divisor}
                                : {16'h0000, bus.divisor};
    end else begin
      ext_num   = bus.is_signed ? {{16{bus.dividend[15]}}, bus.dividend[15:0]}
                                : {16'h0000, bus.dividend[15:0]};
      ext_denom = bus.is_signed ? {{24{bus.divisor[7]}}, bus.divisor[7:0]}
                                : {24'h000000, bus.divisor[7:0]};
    end
  end

  // Signed range holds when every bit above the result sign bit repeats it.
  always_comb begin
    ovf = 1'b0;
    if (lat_signed) begin
      if (lat_wide) begin
        ovf = !((&q_cap[31:15]) || !(|q_cap[31:15]))
              || (!SIGNED_MIN_VALID && (q_cap == 32'hFFFF8000));
      end else begin
        ovf = !((&q_cap[31:7]) || !(|q_cap[31:7]))
              || (!SIGNED_MIN_VALID && (q_cap == 32'hFFFFFF80));
      end
    end else begin
      ovf = lat_wide ? (|q_cap[31:16]) : (|q_cap[31:8]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      lat_wide    <= 1'b0;
      lat_signed  <= 1'b0;
      dbz_pending <= 1'b0;
      num_r       <= 32'h0;
      denom_r     <= 32'h0;
      q_cap       <= 32'h0;
      r_cap       <= 16'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      start_r     <= 1'b0;
      quot_r      <= 16'h0;
      rem_r       <= 16'h0;
    end else if (ce) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            lat_wide   <= bus.wide;
            lat_signed <= bus.is_signed;
            num_r      <= ext_num;
            denom_r    <= ext_denom;
            busy_r     <= 1'b1;
            // A zero divisor never reaches divider2; the trap is raised from CHECK.
            if (ext_denom == 32'h0) begin
              dbz_pending <= 1'b1;
              state       <= S_CHECK;
            end else begin
              dbz_pending <= 1'b0;
              start_r     <= 1'b1;
              state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          start_r <= 1'b0;
          state   <= S_WAIT0;
        end
        S_WAIT0: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.dv_done) begin
            q_cap <= bus.dv_quot;
            r_cap <= bus.dv_rem[15:0];
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          busy_r      <= 1'b0;
          dbz_pending <= 1'b0;
          state       <= S_IDLE;
          if (dbz_pending || ovf) begin
            err_r <= 1'b1;
          end else begin
            done_r <= 1'b1;
            quot_r <= lat_wide ? q_cap[15:0] : {8'h00, q_cap[7:0]};
            rem_r  <= lat_wide ? r_cap       : {8'h00, r_cap[7:0]};
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.div_error = err_r;
  assign bus.quot_out  = quot_r;
  assign bus.rem_out   = rem_r;
  assign bus.dv_start  = start_r;
  assign bus.dv_signed = lat_signed;
  assign bus.dv_num    = num_r;
  assign bus.dv_denom  = denom_r;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - table-driven scoreboard bench for div_sequencer with a 6-cycle divider2 model
module tb_div_sequencer;

  localparam int DV_LAT  = 6;
  localparam int LAT_NRM = 10;
  localparam int LAT_DBZ = 2;

  typedef struct packed {
    logic        wide;
    logic        sgn;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic        err;
    logic        err_b;
    logic        dbz;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic        err_b;
    logic [15:0] q;
    logic [15:0] r;
  } exp_t;

  logic clk;
  logic reset;
  logic ce;
  int   total;
  int   bad;
  int   dv_cnt;
  logic [15:0] shq;
  logic [15:0] shr;
  exp_t sb[$];
  vec_t tbl[14];

  div_sequencer_if ifa();
  div_sequencer_if ifb();

  div_sequencer #(.SIGNED_MIN_VALID(1'b1)) dut_a (.clk(clk), .reset(reset), .ce(ce), .bus(ifa));
  div_sequencer #(.SIGNED_MIN_VALID(1'b0)) dut_b (.clk(clk), .reset(reset), .ce(ce), .bus(ifb));

  assign ifb.req       = ifa.req;
  assign ifb.wide      = ifa.wide;
  assign ifb.is_signed = ifa.is_signed;
  assign ifb.dividend  = ifa.dividend;
  assign ifb.divisor   = ifa.divisor;
  assign ifb.dv_done   = ifa.dv_done;
  assign ifb.dv_quot   = ifa.dv_quot;
  assign ifb.dv_rem    = ifa.dv_rem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] n, input logic [31:0] d, input logic s);
    logic signed [63:0] a;
    logic signed [63:0] b;
    logic signed [63:0] q;
    logic signed [63:0] r;
    a = s ? {{32{n[31]}}, n} : {32'h0, n};
    b = s ? {{32{d[31]}}, d} : {32'h0, d};
    if (b == 64'sd0) return 64'h0;
    q = a / b;
    r = a % b;
    return {q[31:0], r[31:0]};
  endfunction

  // divider2 model: start sampled with ce, done cleared by start, result after DV_LAT ce cycles
  always @(posedge clk) begin
    logic [63:0] res;
    if (reset) begin
      dv_cnt      <= 0;
      ifa.dv_done <= 1'b0;
      ifa.dv_quot <= 32'h0;
      ifa.dv_rem  <= 32'h0;
    end else if (ce) begin
      if (ifa.dv_start) begin
        dv_cnt      <= DV_LAT;
        ifa.dv_done <= 1'b0;
      end else if (dv_cnt != 0) begin
        dv_cnt <= dv_cnt - 1;
        if (dv_cnt == 1) begin
          res = ref_div(ifa.dv_num, ifa.dv_denom, ifa.dv_signed);
          ifa.dv_done <= 1'b1;
          ifa.dv_quot <= res[63:32];
          ifa.dv_rem  <= res[31:0];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic s, input logic [31:0] dd, input logic [15:0] ds,
                              input logic e, input logic eb, input logic z, input logic [15:0] q, input logic [15:0] r);
    vec_t v;
    v.wide = w; v.sgn = s; v.dvd = dd; v.dvs = ds;
    v.err = e; v.err_b = eb; v.dbz = z; v.q = q; v.r = r;
    return v;
  endfunction

  function automatic logic [31:0] ext_denom(input vec_t v);
    if (v.wide) return v.sgn ? {{16{v.dvs[15]}}, v.dvs} : {16'h0, v.dvs};
    return v.sgn ? {{24{v.dvs[7]}}, v.dvs[7:0]} : {24'h0, v.dvs[7:0]};
  endfunction

  task automatic run_op(input int id, input vec_t v, input int stall_at, input int stall_len, input int exp_lat);
    int   n;
    int   starts;
    exp_t e;
    @(negedge clk);
    ifa.req       = 1'b1;
    ifa.wide      = v.wide;
    ifa.is_signed = v.sgn;
    ifa.dividend  = v.dvd;
    ifa.divisor   = v.dvs;
    if (!v.err) begin
      shq = v.q;
      shr = v.r;
    end
    sb.push_back('{v.err, v.err_b, shq, shr});
    @(negedge clk);
    ifa.req       = 1'b0;
    ifa.dividend  = $urandom;
    ifa.divisor   = 16'($urandom);
    ifa.wide      = ~v.wide;
    ifa.is_signed = ~v.sgn;
    chk($sformatf("busy_accept[%0d]", id), {31'h0, ifa.busy}, 32'h1);
    if (!v.dbz) chk($sformatf("dv_denom[%0d]", id), ifa.dv_denom, ext_denom(v));
    n = 1;
    starts = 0;
    while (!(ifa.done || ifa.div_error) && n < 100) begin
      ce = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (ifa.dv_start && ce) starts++;
      @(negedge clk);
      n++;
    end
    ce = 1'b1;
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL timeout[%0d]: got no done/div_error within %0d cycles, want one", id, n);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk($sformatf("latency[%0d]", id), n, exp_lat);
    chk($sformatf("dv_start_count[%0d]", id), starts, v.dbz ? 0 : 1);
    chk($sformatf("div_error[%0d]", id), {31'h0, ifa.div_error}, {31'h0, e.err});
    chk($sformatf("done[%0d]", id), {31'h0, ifa.done}, {31'h0, !e.err});
    chk($sformatf("busy_end[%0d]", id), {31'h0, ifa.busy}, 32'h0);
    chk($sformatf("quot_out[%0d]", id), {16'h0, ifa.quot_out}, {16'h0, e.q});
    chk($sformatf("rem_out[%0d]", id), {16'h0, ifa.rem_out}, {16'h0, e.r});
    chk($sformatf("b_div_error[%0d]", id), {31'h0, ifb.div_error}, {31'h0, e.err_b});
    chk($sformatf("b_done[%0d]", id), {31'h0, ifb.done}, {31'h0, !e.err_b});
    ce = 1'b0;
    @(negedge clk);
    chk($sformatf("pulse_hold_ce0[%0d]", id), {30'h0, ifa.done, ifa.div_error}, {30'h0, !e.err, e.err});
    ce = 1'b1;
    @(negedge clk);
    chk($sformatf("pulse_clear[%0d]", id), {30'h0, ifa.done, ifa.div_error}, 32'h0);
  endtask

  initial begin
    int n;
    int seen;
    total = 0;
    bad   = 0;
    shq   = 16'h0;
    shr   = 16'h0;

    tbl[0]  = mk(1, 0, 32'h00010000, 16'h0002, 0, 0, 0, 16'h8000, 16'h0000);
    tbl[1]  = mk(1, 0, 32'h00020000, 16'h0001, 1, 1, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 1, 32'h0000FF9C, 16'h0007, 0, 0, 0, 16'h00F2, 16'h00FE);
    tbl[3]  = mk(1, 0, 32'h12345678, 16'h0000, 1, 1, 1, 16'h0000, 16'h0000);
    tbl[4]  = mk(1, 1, 32'hFFFF8000, 16'h0001, 0, 1, 0, 16'h8000, 16'h0000);
    tbl[5]  = mk(1, 1, 32'h80000000, 16'hFFFF, 1, 1, 0, 16'h0000, 16'h0000);
    tbl[6]  = mk(0, 0, 32'hABCD0064, 16'h1205, 0, 0, 0, 16'h0014, 16'h0000);
    tbl[7]  = mk(0, 0, 32'h00001000, 16'h0002, 1, 1, 0, 16'h0000, 16'h0000);
    tbl[8]  = mk(0, 1, 32'h00000080, 16'h00FF, 0, 1, 0, 16'h0080, 16'h0000);
    tbl[9]  = mk(1, 1, 32'h000186A0, 16'hFFFD, 1, 1, 0, 16'h0000, 16'h0000);
    tbl[10] = mk(1, 1, 32'h00000007, 16'hFFFE, 0, 0, 0, 16'hFFFD, 16'h0001);
    tbl[11] = mk(0, 0, 32'h00000055, 16'h0100, 1, 1, 1, 16'h0000, 16'h0000);
    tbl[12] = mk(0, 0, 32'h000000FF, 16'h0010, 0, 0, 0, 16'h000F, 16'h000F);
    tbl[13] = mk(1, 1, 32'hFFFFFFF9, 16'h0002, 0, 0, 0, 16'hFFFD, 16'hFFFF);

    ce = 1'b1;
    reset = 1'b1;
    ifa.req = 1'b0;
    ifa.wide = 1'b0;
    ifa.is_signed = 1'b0;
    ifa.dividend = 32'h0;
    ifa.divisor = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_flags", {28'h0, ifa.busy, ifa.done, ifa.div_error, ifa.dv_start}, 32'h0);
    chk("rst_quot", {16'h0, ifa.quot_out}, 32'h0);
    chk("rst_rem", {16'h0, ifa.rem_out}, 32'h0);
    chk("rst_dv_num", ifa.dv_num, 32'h0);
    chk("rst_dv_denom", ifa.dv_denom, 32'h0);

    for (int i = 0; i < 14; i++) begin
      run_op(i, tbl[i], 0, 0, tbl[i].dbz ? LAT_DBZ : LAT_NRM);
    end

    // ce stalls: in WAIT and in ISSUE (dv_start must stay high and count once)
    run_op(20, tbl[0], 5, 3, LAT_NRM + 3);
    run_op(21, tbl[2], 1, 2, LAT_NRM + 2);

    // reset while waiting on divider2
    @(negedge clk);
    ifa.req = 1'b1;
    ifa.wide = 1'b1;
    ifa.is_signed = 1'b0;
    ifa.dividend = 32'h00010000;
    ifa.divisor = 16'h0002;
    sb.push_back('{1'b0, 1'b0, 16'h8000, 16'h0000});
    @(negedge clk);
    ifa.req = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    shq = 16'h0;
    shr = 16'h0;
    chk("midrst_flags", {28'h0, ifa.busy, ifa.done, ifa.div_error, ifa.dv_start}, 32'h0);
    chk("midrst_quot", {16'h0, ifa.quot_out}, 32'h0);
    chk("midrst_dv_num", ifa.dv_num, 32'h0);
    seen = 0;
    for (n = 0; n < 15; n++) begin
      if (ifa.done || ifa.div_error || ifa.busy) seen++;
      @(negedge clk);
    end
    chk("midrst_no_pulse", seen, 0);

    run_op(30, tbl[12], 0, 0, LAT_NRM);
    run_op(31, tbl[1], 0, 0, LAT_NRM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by 500000, want finish");
    $fatal(1);
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Control stage for the V30 DIV/IDIV instructions. It sits directly above divider2 and consumes its result.
- Takes the raw instruction operands (AX or DX:AX, plus an 8/16-bit divisor) and extends them to 32 bits. It then issues the division to divider2 and waits for completion.
- Applies x86 quotient-range and divide-by-zero rules, and returns either a truncated quotient/remainder or a divide-error trap request to the execution unit.

Parameters:
SIGNED_MIN_VALID, 1, 1: signed quotient equal to -128 (byte) or -32768 (word) is accepted. 0: that value raises div_error (8086-compatible behaviour).

Ports:
clk  in  1  clock
reset  in  1  reset
ce  in  1  clock enable; all state advances only when ce=1
req  in  1  start request; sampled in IDLE with ce=1
wide  in  1  1 = word op (DX:AX / 16-bit), 0 = byte op (AX / 8-bit)
is_signed  in  1  1 = IDIV, 0 = DIV
dividend  in  32  DX:AX; only [15:0] used when wide=0
divisor  in  16  only [7:0] used when wide=0
busy  out  1  high from accepted req until done/div_error
done  out  1  one-ce-cycle pulse: result valid
div_error  out  1  one-ce-cycle pulse: divide error, results not updated
quot_out  out  16  quotient; byte op: {8'h00, q[7:0]}
rem_out  out  16  remainder; byte op: {8'h00, r[7:0]}
dv_start  out  1  start to divider2
dv_signed  out  1  is_signed to divider2
dv_num  out  32  extended dividend to divider2
dv_denom  out  32  extended divisor to divider2
dv_done  in  1  divider2 done (level, cleared by next start)
dv_quot  in  32  divider2 quotient (sign-corrected)
dv_rem  in  32  divider2 remainder (sign of dividend)

Behaviour:
- Clocking: single clock clk. reset is synchronous and active-high. reset overrides ce and returns all state to power-up values.
- Reset values: state=IDLE; busy, done, div_error, dv_start all 0; quot_out, rem_out, dv_num, dv_denom 0; operand latches 0.
- Extension:
  - word op: num = dividend; denom = sign- or zero-extend(divisor[15:0]).
  - byte op: num = extend(dividend[15:0]); denom = extend(divisor[7:0]).
  - Sign extension when is_signed=1, zero extension otherwise.
  - Results are latched on req acceptance; later input changes have no effect.
- FSM: IDLE -> ISSUE -> WAIT0 -> WAIT -> CHECK -> IDLE. All transitions are gated by ce.
- IDLE:
  - On req=1, latch wide, is_signed, num and denom; set busy=1.
  - If the extended divisor is 0, go to CHECK with a pending-dbz flag set. dv_start is never asserted in this case.
  - Otherwise go to ISSUE.
- ISSUE: dv_start=1 for exactly this one ce cycle. dv_num, dv_denom and dv_signed are stable from here until IDLE. Next state is WAIT0.
- WAIT0: guard cycle. dv_done is ignored here because divider2 clears it one cycle after start. Next state is WAIT.
- WAIT: stay while dv_done=0. On dv_done=1, capture dv_quot and dv_rem and go to CHECK. dv_done stays asserted across ce=0 cycles, so no sticky flag is needed.
- CHECK overflow rules (q = captured quotient):
  - unsigned word: q[31:16] != 0.
  - unsigned byte: q[31:8] != 0.
  - signed word: q[31:15] not all equal.
  - signed byte: q[31:7] not all equal.
  - SIGNED_MIN_VALID=0 additionally faults on q == 0xFFFF8000 (word) or q == 0xFFFFFF80 (byte).
- CHECK outcome:
  - If the pending-dbz flag is set or overflow is detected: div_error=1; quot_out and rem_out hold their previous values.
  - Otherwise: done=1, and quot_out/rem_out are loaded from the low 16 (word) or low 8 (byte) bits.
  - In both cases busy=0 and next state is IDLE.
- Latency:
  - Divide by zero: div_error in the 2nd ce cycle after the accepting cycle.
  - Normal: done/div_error in the ce cycle after dv_done is first seen in WAIT.
- Pulse width: done and div_error are high for one ce=1 cycle. They hold through ce=0 cycles and clear on the next ce=1 cycle.
- Back-to-back: req is ignored while busy=1. A req in the same cycle that CHECK completes is not accepted; it is accepted the next ce cycle if still high.
- Mid-operation reset: any state returns to IDLE, no done or div_error is issued, and outputs take reset values. divider2 shares the reset.
- ce=0: state, outputs and dv_start are frozen. dv_start therefore stays high across ce=0 in ISSUE; divider2 samples it only with ce.

Test Plan:
1. Unsigned word 0x00010000 / 0x0002 -> dv_start one cycle; done; quot_out=0x8000, rem_out=0x0000; div_error=0.
2. Unsigned word 0x00020000 / 0x0001 -> div_error pulse; quot_out/rem_out keep values from test 1; busy drops with the pulse.
3. Signed byte AX=0xFF9C (-100) / 0x07 -> quot_out=0x00F2 (-14), rem_out=0x00FE (-2), done.
4. Divisor 0x0000, word, unsigned -> dv_start never asserted; div_error 2 ce cycles after req; busy 0 afterwards.
5. Signed word 0xFFFF8000 / 0x0001 -> with SIGNED_MIN_VALID=1: done, quot_out=0x8000. With SIGNED_MIN_VALID=0: div_error. Also 0x80000000 / 0xFFFF -> div_error for both values.
6. Model divider with 6-cycle latency:
   - Toggle ce low for 3 cycles during WAIT -> result unchanged and done delayed by the stall.
   - Assert reset in WAIT -> IDLE, busy=0, no done/div_error.
   - A new req after reset completes normally.
